// File: rtl/opamp_meas_seq.sv
// Wishbone-programmable op-amp settling sequencer: drives bias, stimulus and mux
// controls, then counts cycles until the synchronised comparator flips.
module opamp_meas_seq #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   input  logic        cmp_i,
   output logic        bias_en_o,
   output logic        stim_o,
   output logic [1:0]  sw_sel_o,
   output logic        busy_o,
   output logic        irq_o
);

   localparam int unsigned CW1         = CNT_W + 1;
   localparam logic [2:0]  OFF_CTRL    = 3'd0;
   localparam logic [2:0]  OFF_SETTLE  = 3'd1;
   localparam logic [2:0]  OFF_TIMEOUT = 3'd2;
   localparam logic [2:0]  OFF_STATUS  = 3'd3;
   localparam logic [2:0]  OFF_RESULT  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_MEAS   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic                   r_ack;
   logic [31:0]            r_dat;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt, r_settle, r_timeout, r_result;
   logic [1:0]             r_sw_sel;
   logic                   r_irq_en, r_stim_pol, r_done, r_tout, r_cmp_ref;
   logic                   r_bias, r_stim, r_busy, r_irq;

   logic                   w_hit, w_req, w_wr, w_busy, w_cmp_s, w_unused;
   logic                   w_wr_ctrl, w_wr_stat, w_start, w_abort, w_pol_nxt;
   logic                   w_settle_end, w_flip, w_tmo_hit, w_cnt_sat;
   logic [2:0]             w_off;
   logic [31:0]            w_rd_data;
   logic [CNT_W-1:0]       w_settle_eff;

   logic [CNT_W-1:0]       w_cnt_nxt, w_res_val, w_settle_nxt, w_timeout_nxt, w_result_nxt;
   logic                   w_cap_ref, w_res_ld, w_tout_set, w_done_set, w_clr_flags;
   logic                   w_bias_nxt, w_stim_nxt;
   logic [1:0]             w_sw_sel_nxt;
   logic                   w_irq_en_nxt, w_done_nxt, w_tout_nxt;

   // Byte-enable merge of write data into a counter-width register
   function automatic logic [CNT_W-1:0] f_merge(input logic [CNT_W-1:0] old,
                                                input logic [31:0]      dat,
                                                input logic [3:0]       sel);
      logic [31:0] v;
      v = 32'(old);
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) v[8*b +: 8] = dat[8*b +: 8];
      end
      return v[CNT_W-1:0];
   endfunction

   assign w_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
   assign w_req     = w_hit & ~r_ack;
   assign w_wr      = w_hit & r_ack & wbs_we_i;
   assign w_off     = wbs_adr_i[4:2];
   assign w_busy    = (r_state != S_IDLE);
   assign w_unused  = ^wbs_adr_i[1:0];
   assign w_cmp_s   = r_sync[SYNC_STAGES-1];
   assign w_wr_ctrl = w_wr & (w_off == OFF_CTRL) & wbs_sel_i[0];
   assign w_wr_stat = w_wr & (w_off == OFF_STATUS) & wbs_sel_i[0];
   assign w_start   = w_wr_ctrl & wbs_dat_i[0];
   assign w_abort   = w_wr_ctrl & wbs_dat_i[1];
   assign w_pol_nxt = (w_wr_ctrl & ~w_busy) ? wbs_dat_i[5] : r_stim_pol;

   assign w_settle_eff = (r_settle == '0) ? CNT_W'(1) : r_settle;
   assign w_settle_end = (CW1'(r_cnt) + CW1'(1)) >= CW1'(w_settle_eff);
   assign w_flip       = (w_cmp_s != r_cmp_ref);
   assign w_tmo_hit    = (r_cnt == r_timeout);
   assign w_cnt_sat    = &r_cnt;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start && !w_abort) w_state_nxt = S_SETTLE;
         S_SETTLE: begin
            if (w_abort)           w_state_nxt = S_IDLE;
            else if (w_settle_end) w_state_nxt = S_MEAS;
         end
         S_MEAS: begin
            if (w_abort)                  w_state_nxt = S_IDLE;
            else if (w_flip || w_tmo_hit) w_state_nxt = S_DONE;
         end
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath strobes and next-cycle pin levels
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_cap_ref   = 1'b0;
      w_res_ld    = 1'b0;
      w_res_val   = r_result;
      w_tout_set  = 1'b0;
      w_done_set  = 1'b0;
      w_clr_flags = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_state_nxt == S_SETTLE) begin
               w_cnt_nxt   = '0;
               w_clr_flags = 1'b1;
            end
         end
         S_SETTLE: begin
            if (w_state_nxt == S_MEAS) begin
               w_cnt_nxt = '0;
               w_cap_ref = 1'b1;
            end else if (w_state_nxt == S_SETTLE) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_MEAS: begin
            if (w_state_nxt == S_DONE) begin
               w_res_ld = 1'b1;
               if (w_flip) begin
                  w_res_val = r_cnt;
               end else begin
                  w_res_val  = r_timeout;
                  w_tout_set = 1'b1;
               end
            end else if ((w_state_nxt == S_MEAS) && !w_cnt_sat) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_DONE:  w_done_set = 1'b1;
         default: ;
      endcase
      w_bias_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEAS);
      w_stim_nxt = (w_state_nxt == S_SETTLE) ? w_pol_nxt :
                   (w_state_nxt == S_MEAS)   ? ~w_pol_nxt : 1'b0;
   end

   // Register file next values; FSM set of DONE overrides a same-cycle W1C
   always_comb begin
      w_settle_nxt  = r_settle;
      w_timeout_nxt = r_timeout;
      w_sw_sel_nxt  = r_sw_sel;
      w_irq_en_nxt  = r_irq_en;
      w_done_nxt    = r_done;
      w_tout_nxt    = r_tout;
      w_result_nxt  = r_result;
      if (w_wr_ctrl) begin
         w_irq_en_nxt = wbs_dat_i[4];
         if (!w_busy) w_sw_sel_nxt = wbs_dat_i[3:2];
      end
      if (w_wr && !w_busy && (w_off == OFF_SETTLE))
         w_settle_nxt = f_merge(r_settle, wbs_dat_i, wbs_sel_i);
      if (w_wr && !w_busy && (w_off == OFF_TIMEOUT))
         w_timeout_nxt = f_merge(r_timeout, wbs_dat_i, wbs_sel_i);
      if (w_wr_stat) begin
         if (wbs_dat_i[1]) w_done_nxt = 1'b0;
         if (wbs_dat_i[2]) w_tout_nxt = 1'b0;
      end
      if (w_clr_flags) begin
         w_done_nxt = 1'b0;
         w_tout_nxt = 1'b0;
      end
      if (w_tout_set) w_tout_nxt   = 1'b1;
      if (w_done_set) w_done_nxt   = 1'b1;
      if (w_res_ld)   w_result_nxt = w_res_val;
   end

   always_comb begin
      w_rd_data = '0;
      case (w_off)
         OFF_CTRL:    w_rd_data = {26'd0, r_stim_pol, r_irq_en, r_sw_sel, 2'b00};
         OFF_SETTLE:  w_rd_data = 32'(r_settle);
         OFF_TIMEOUT: w_rd_data = 32'(r_timeout);
         OFF_STATUS:  w_rd_data = {29'd0, r_tout, r_done, w_busy};
         OFF_RESULT:  w_rd_data = 32'(r_result);
         default:     w_rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_ack      <= 1'b0;
         r_dat      <= '0;
         r_sync     <= '0;
         r_cnt      <= '0;
         r_settle   <= '0;
         r_timeout  <= '0;
         r_result   <= '0;
         r_sw_sel   <= '0;
         r_irq_en   <= 1'b0;
         r_stim_pol <= 1'b0;
         r_done     <= 1'b0;
         r_tout     <= 1'b0;
         r_cmp_ref  <= 1'b0;
         r_bias     <= 1'b0;
         r_stim     <= 1'b0;
         r_busy     <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_ack      <= w_req;
         r_dat      <= (w_req && !wbs_we_i) ? w_rd_data : '0;
         r_sync     <= {r_sync[SYNC_STAGES-2:0], cmp_i};
         r_cnt      <= w_cnt_nxt;
         r_settle   <= w_settle_nxt;
         r_timeout  <= w_timeout_nxt;
         r_result   <= w_result_nxt;
         r_sw_sel   <= w_sw_sel_nxt;
         r_irq_en   <= w_irq_en_nxt;
         r_stim_pol <= w_pol_nxt;
         r_done     <= w_done_nxt;
         r_tout     <= w_tout_nxt;
         if (w_cap_ref) r_cmp_ref <= w_cmp_s;
         r_bias     <= w_bias_nxt;
         r_stim     <= w_stim_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_irq      <= w_done_nxt & w_irq_en_nxt;
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign bias_en_o = r_bias;
   assign stim_o    = r_stim;
   assign sw_sel_o  = r_sw_sel;
   assign busy_o    = r_busy;
   assign irq_o     = r_irq;

endmodule
